// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq
//   Converts a signed two's-complement value to three BCD digits for the
//   seven-segment display stage. The conversion runs as a shift-add-3
//   (double-dabble) sequence, one magnitude bit per clock, and uses a
//   start/busy/done handshake.
//
//   The 10-bit BCD result can show 0..MAX_MAG. Anything larger is flagged as
//   overflow, and the digits are then forced to zero.
//
// Ports
//   clk       in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   start     in   conversion request, only looked at while idle
//   value_in  in   signed operand, captured when start is accepted
//   busy      out  high from the cycle after acceptance through the done cycle
//   done      out  one-cycle pulse; the result outputs are updated in this cycle
//   bcd_out   out  {hund[1:0], tens[3:0], ones[3:0]}, held until the next done
//   negative  out  captured value was < 0, held until the next done
//   overflow  out  |captured value| > MAX_MAG, held until the next done
//
// state | meaning
// IDLE  | waiting for start; the last result is held on the outputs
// SHIFT | WIDTH shift-add-3 steps, cnt counts 0..WIDTH-1
// DONE  | result registered on entry, done pulse, then back to IDLE

module bin_to_bcd_seq #(
  parameter int WIDTH   = 10,
  parameter int MAX_MAG = 399
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] value_in,
  output logic             busy,
  output logic             done,
  output logic [9:0]       bcd_out,
  output logic             negative,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int               CNT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MAX_MAG_W = WIDTH'(MAX_MAG);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mag;
  logic             sign_r;
  logic             ovf_r;
  logic [11:0]      scratch;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] value_abs;
  logic             ovf_cap;
  logic [11:0]      scratch_adj;
  logic [11:0]      scratch_nxt;
  logic             last_step;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // The most negative input maps to 2^(WIDTH-1), which still fits unsigned.
  assign value_abs = value_in[WIDTH-1] ? (~value_in) + WIDTH'(1) : value_in;
  assign ovf_cap   = (value_abs > MAX_MAG_W);

  // The hundreds digit never goes above 5, so dropping its top bit after the
  // shift loses nothing.
  assign scratch_adj = {add3(scratch[11:8]), add3(scratch[7:4]), add3(scratch[3:0])};
  assign scratch_nxt = 12'({scratch_adj, mag[WIDTH-1]});
  assign last_step   = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_step) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mag      <= '0;
      sign_r   <= 1'b0;
      ovf_r    <= 1'b0;
      scratch  <= '0;
      cnt      <= '0;
      bcd_out  <= '0;
      negative <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mag     <= value_abs;
            sign_r  <= value_in[WIDTH-1];
            ovf_r   <= ovf_cap;
            scratch <= '0;
            cnt     <= '0;
          end
        end
        SHIFT: begin
          scratch <= scratch_nxt;
          mag     <= {mag[WIDTH-2:0], 1'b0};
          cnt     <= cnt + 1'b1;
          // The result registers load on the same edge as the last shift, so
          // they show the new value for the whole done cycle.
          if (last_step) begin
            bcd_out  <= ovf_r ? 10'd0 : scratch_nxt[9:0];
            negative <= sign_r;
            overflow <= ovf_r;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Testbench for bin_to_bcd_seq: table vectors, random values checked against
// an arithmetic model, and hand-written handshake/reset sequences.

module tb_bin_to_bcd_seq;

  localparam int WIDTH = 10;

  logic             clk;
  logic             reset_n;
  logic             start;
  logic [WIDTH-1:0] value_in;
  logic             busy;
  logic             done;
  logic [9:0]       bcd_out;
  logic             negative;
  logic             overflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0] prev_bcd;
  logic       prev_neg;
  logic       prev_ovf;

  bin_to_bcd_seq #(.WIDTH(WIDTH), .MAX_MAG(399)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .value_in (value_in),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd_out),
    .negative (negative),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "global timeout");
  end

  typedef struct {
    logic [9:0] v;
    logic [9:0] bcd;
    logic       neg;
    logic       ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Decimal arithmetic on the signed value; no knowledge of the shift sequence.
  function automatic void model(input logic [9:0] v, output logic [9:0] b,
                                output logic n, output logic o);
    int sv, m, h, t, u;
    sv = $signed(v);
    m  = (sv < 0) ? -sv : sv;
    n  = (sv < 0);
    o  = (m > 399);
    h  = m / 100;
    t  = (m / 10) % 10;
    u  = m % 10;
    b  = o ? 10'd0 : {h[1:0], t[3:0], u[3:0]};
  endfunction

  // One full conversion: latency, hold-stability while busy, result, return to idle.
  task automatic run_conv(input logic [9:0] v, input logic [9:0] eb,
                          input logic en, input logic eo, input string tag);
    int  k;
    bit  held_ok;
    @(negedge clk);
    start    = 1'b1;
    value_in = v;
    @(posedge clk);
    #1;
    start    = 1'b0;
    value_in = 10'($urandom);
    chk({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
    held_ok = 1'b1;
    k = 0;
    while (done !== 1'b1 && k < 40) begin
      if (bcd_out !== prev_bcd || negative !== prev_neg || overflow !== prev_ovf)
        held_ok = 1'b0;
      value_in = 10'($urandom);
      @(posedge clk);
      #1;
      k++;
    end
    chk({tag, "_latency"}, 32'(k), 32'(WIDTH));
    chk({tag, "_held_while_busy"}, 32'(held_ok), 32'd1);
    chk({tag, "_bcd"}, 32'(bcd_out), 32'(eb));
    chk({tag, "_neg"}, 32'(negative), 32'(en));
    chk({tag, "_ovf"}, 32'(overflow), 32'(eo));
    @(posedge clk);
    #1;
    chk({tag, "_idle_after_done"}, 32'({busy, done}), 32'd0);
    prev_bcd = eb;
    prev_neg = en;
    prev_ovf = eo;
  endtask

  vec_t vecs[10];

  initial begin
    int         done_cnt, done_at, done_1, done_2, k;
    logic [9:0] rv, eb;
    logic       en, eo;

    vecs[0] = '{10'd255,  10'b10_0101_0101, 1'b0, 1'b0};
    vecs[1] = '{10'h3FF,  10'b00_0000_0001, 1'b1, 1'b0};
    vecs[2] = '{10'd399,  10'b11_1001_1001, 1'b0, 1'b0};
    vecs[3] = '{10'd400,  10'b00_0000_0000, 1'b0, 1'b1};
    vecs[4] = '{10'h200,  10'b00_0000_0000, 1'b1, 1'b1};
    vecs[5] = '{10'd0,    10'b00_0000_0000, 1'b0, 1'b0};
    vecs[6] = '{10'd123,  10'b01_0010_0011, 1'b0, 1'b0};
    vecs[7] = '{10'h271,  10'b11_1001_1001, 1'b1, 1'b0};  // -399
    vecs[8] = '{10'h270,  10'b00_0000_0000, 1'b1, 1'b1};  // -400
    vecs[9] = '{10'd90,   10'b00_1001_0000, 1'b0, 1'b0};

    reset_n  = 1'b0;
    start    = 1'b0;
    value_in = '0;
    prev_bcd = '0;
    prev_neg = 1'b0;
    prev_ovf = 1'b0;
    #23;
    chk("reset_busy_done", 32'({busy, done}), 32'd0);
    chk("reset_outputs", 32'({bcd_out, negative, overflow}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++)
      run_conv(vecs[i].v, vecs[i].bcd, vecs[i].neg, vecs[i].ovf, $sformatf("vec%0d", i));

    for (int i = 0; i < 30; i++) begin
      rv = 10'($urandom_range(0, 1023));
      model(rv, eb, en, eo);
      run_conv(rv, eb, en, eo, $sformatf("rnd%0d_v%0d", i, $signed(rv)));
    end

    // start while busy (SHIFT and DONE) is ignored
    @(negedge clk);
    start    = 1'b1;
    value_in = 10'd7;
    @(posedge clk);
    #1;
    start    = 1'b0;
    done_cnt = 0;
    done_at  = -1;
    for (k = 1; k <= 2 * WIDTH + 6; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
        chk("busy_ignore_bcd", 32'(bcd_out), 32'd7);
      end
      if (k == 3)         begin start = 1'b1; value_in = 10'd9; end
      if (k == 4)         start = 1'b0;
      if (k == WIDTH)     begin start = 1'b1; value_in = 10'd9; end
      if (k == WIDTH + 1) begin
        start = 1'b0;
        chk("busy_ignore_idle", 32'(busy), 32'd0);
      end
    end
    chk("busy_ignore_done_count", 32'(done_cnt), 32'd1);
    chk("busy_ignore_done_time", 32'(done_at), 32'(WIDTH));
    prev_bcd = 10'd7;
    prev_neg = 1'b0;
    prev_ovf = 1'b0;

    // start held high: a new conversion every WIDTH+2 cycles
    @(negedge clk);
    start    = 1'b1;
    value_in = 10'd5;
    @(posedge clk);
    #1;
    done_1 = -1;
    done_2 = -1;
    for (k = 1; k <= 2 * WIDTH + 4; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        if (done_1 < 0) done_1 = k;
        else if (done_2 < 0) done_2 = k;
      end
    end
    chk("held_start_first_done", 32'(done_1), 32'(WIDTH));
    chk("held_start_second_done", 32'(done_2), 32'(2 * WIDTH + 2));
    chk("held_start_bcd", 32'(bcd_out), 32'd5);
    start = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("held_start_third_done", 32'(done), 32'd1);
    @(posedge clk);
    #1;
    prev_bcd = 10'd5;

    // leave non-zero outputs, then abort a conversion with reset
    run_conv(10'h3FF, 10'd1, 1'b1, 1'b0, "pre_abort");
    @(negedge clk);
    start    = 1'b1;
    value_in = 10'd255;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_busy_done", 32'({busy, done}), 32'd0);
    chk("abort_outputs", 32'({bcd_out, negative, overflow}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    prev_bcd = '0;
    prev_neg = 1'b0;
    prev_ovf = 1'b0;
    done_cnt = 0;
    for (k = 0; k < WIDTH + 6; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) done_cnt++;
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    run_conv(10'd123, 10'b01_0010_0011, 1'b0, 1'b0, "after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
